// File: rtl/prefetch_unit_pkg.sv
// Shared constants, bus FSM state encoding and the segment:offset address helper
// used by the prefetch unit.
package prefetch_unit_pkg;

    localparam logic [15:0] RESET_CS = 16'hffff;
    localparam logic [15:0] RESET_IP = 16'h0000;
    localparam int unsigned PHYS_AW  = 20;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ABORT
    } state_e;

    // Word address of seg:off; the 20-bit physical address wraps modulo 2^20.
    function automatic logic [PHYS_AW-2:0] word_address(input logic [15:0] seg,
                                                        input logic [15:0] off);
        logic [PHYS_AW-1:0] phys;
        phys = {seg, 4'h0} + {4'h0, off};
        return phys[PHYS_AW-1:1];
    endfunction

endpackage

// File: rtl/prefetch_unit_if.sv
// Memory read bus and instruction byte FIFO write port driven by the prefetch unit.
interface prefetch_unit_if;

    logic        mem_access;
    logic        mem_ack;
    logic [18:0] mem_address;
    logic [15:0] mem_data;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_full;
    logic        fifo_reset;

    modport master (
        output mem_access, mem_address, fifo_wr_en, fifo_wr_data, fifo_reset,
        input  mem_ack, mem_data, fifo_full
    );

    modport slave (
        input  mem_access, mem_address, fifo_wr_en, fifo_wr_data, fifo_reset,
        output mem_ack, mem_data, fifo_full
    );

endinterface

// File: rtl/prefetch_word_buffer.sv
// One-word staging buffer between the memory bus and the FIFO: loads a fetched word,
// selects odd/even bytes and drains them one per cycle.
module prefetch_word_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        load,
    input  logic        odd,
    input  logic        bypass,
    input  logic        fifo_full,
    input  logic [15:0] data,
    output logic [1:0]  count,
    output logic        wr_en,
    output logic [7:0]  wr_data
);

    logic [15:0] word_q, word_d;
    logic [1:0]  count_q, count_d;
    logic        ptr_q, ptr_d;
    logic        pop;

    assign pop   = (count_q != 2'd0) & ~fifo_full & ~flush;
    assign count = count_q;

    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        if (flush) begin
            count_d = 2'd0;
        end else if (load) begin
            word_d  = data;
            // An odd start or a bypassed low byte leaves only the high byte to drain.
            ptr_d   = odd | bypass;
            count_d = odd ? 2'd1 : 2'd2;
            if (bypass) begin
                count_d = count_d - 2'd1;
            end
        end else if (pop) begin
            count_d = count_q - 2'd1;
            ptr_d   = 1'b1;
        end
    end

    always_comb begin
        wr_en   = pop | bypass;
        wr_data = ptr_q ? word_q[15:8] : word_q[7:0];
        if (bypass) begin
            wr_data = odd ? data[15:8] : data[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q  <= '0;
            count_q <= 2'd0;
            ptr_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: rtl/prefetch_unit.sv
// Prefetch unit: fetches code words at cs:ip and feeds the instruction byte FIFO.
// Define PREFETCH_BYPASS_EN to forward the first byte straight from mem_data on mem_ack.
module prefetch_unit #(
    parameter logic [15:0] RESET_IP = prefetch_unit_pkg::RESET_IP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     cs,
    input  logic [15:0]     new_ip,
    input  logic            load_new_ip,
    prefetch_unit_if.master bus
);

    import prefetch_unit_pkg::*;

    state_e      state_q, state_d;
    logic [15:0] ip_q, ip_d;
    logic [18:0] addr_q, addr_d;
    logic        buf_load;
    logic        bypass;
    logic [1:0]  buf_count;

`ifdef PREFETCH_BYPASS_EN
    assign bypass = buf_load & ~bus.fifo_full;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ip_d     = ip_q;
        addr_d   = addr_q;
        buf_load = 1'b0;
        if (load_new_ip) begin
            ip_d = new_ip;
        end
        unique case (state_q)
            IDLE: begin
                // A redirect empties the buffer, so it may issue at the new target at once.
                if (load_new_ip || buf_count == 2'd0) begin
                    state_d = FETCH;
                    addr_d  = word_address(cs, ip_d);
                end
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    state_d = IDLE;
                    if (!load_new_ip) begin
                        buf_load = 1'b1;
                        ip_d     = ip_q + (ip_q[0] ? 16'd1 : 16'd2);
                    end
                end else if (load_new_ip) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if (bus.mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ip_q    <= RESET_IP;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.mem_access  = (state_q != IDLE);
    assign bus.mem_address = addr_q;
    assign bus.fifo_reset  = load_new_ip;

    prefetch_word_buffer u_buffer (
        .clk       (clk),
        .reset     (reset),
        .flush     (load_new_ip),
        .load      (buf_load),
        .odd       (ip_q[0]),
        .bypass    (bypass),
        .fifo_full (bus.fifo_full),
        .data      (bus.mem_data),
        .count     (buf_count),
        .wr_en     (bus.fifo_wr_en),
        .wr_data   (bus.fifo_wr_data)
    );

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: byte-queue reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_prefetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cs;
    logic [15:0] new_ip;
    logic        load_new_ip;

    prefetch_unit_if bus ();

    prefetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .cs          (cs),
        .new_ip      (new_ip),
        .load_new_ip (load_new_ip),
        .bus         (bus)
    );

    always #5 clk = ~clk;

`ifdef PREFETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_q[$];
    bit          m_busy;
    bit          m_abort;
    logic [15:0] m_ip;
    logic [18:0] m_addr;
    logic [7:0]  pushed[$];
    logic [18:0] addrs[$];
    bit          prev_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] wa(input logic [15:0] seg, input logic [15:0] off);
        logic [19:0] p;
        p = {seg, 4'h0} + {4'h0, off};
        return p[19:1];
    endfunction

    // Reference model: outputs from a byte queue, a bus-busy flag and a discard flag.
    initial begin
        logic       exp_wr;
        logic [7:0] exp_data;
        bit         start_empty;
        bit         byp;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_q.delete();
                m_busy   = 0;
                m_abort  = 0;
                m_ip     = 16'h0000;
                m_addr   = '0;
                prev_acc = 0;
            end else begin
                exp_wr   = 1'b0;
                exp_data = 8'h00;
                byp      = 0;
                if (m_q.size() != 0 && !bus.fifo_full && !load_new_ip) begin
                    exp_wr   = 1'b1;
                    exp_data = m_q[0];
                end else if (BYPASS && m_busy && !m_abort && bus.mem_ack && !load_new_ip
                             && !bus.fifo_full) begin
                    byp      = 1;
                    exp_wr   = 1'b1;
                    exp_data = m_ip[0] ? bus.mem_data[15:8] : bus.mem_data[7:0];
                end
                check("mem_access", 32'(bus.mem_access), 32'(m_busy));
                if (m_busy) check("mem_address", 32'(bus.mem_address), 32'(m_addr));
                check("fifo_reset", 32'(bus.fifo_reset), 32'(load_new_ip));
                check("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(exp_wr));
                if (exp_wr) check("fifo_wr_data", 32'(bus.fifo_wr_data), 32'(exp_data));
                if (bus.fifo_wr_en) pushed.push_back(bus.fifo_wr_data);
                if (bus.mem_access && !prev_acc) addrs.push_back(bus.mem_address);
                prev_acc = bus.mem_access;

                start_empty = (m_q.size() == 0);
                if (exp_wr && !byp) void'(m_q.pop_front());
                if (load_new_ip) begin
                    m_q.delete();
                    m_ip = new_ip;
                    if (!m_busy) begin
                        m_busy  = 1;
                        m_abort = 0;
                        m_addr  = wa(cs, new_ip);
                    end else if (bus.mem_ack) begin
                        m_busy  = 0;
                        m_abort = 0;
                    end else begin
                        m_abort = 1;
                    end
                end else if (m_busy) begin
                    if (bus.mem_ack) begin
                        if (!m_abort) begin
                            if (m_ip[0]) begin
                                if (!byp) m_q.push_back(bus.mem_data[15:8]);
                            end else begin
                                if (!byp) m_q.push_back(bus.mem_data[7:0]);
                                m_q.push_back(bus.mem_data[15:8]);
                            end
                            m_ip = m_ip + (m_ip[0] ? 16'd1 : 16'd2);
                        end
                        m_busy  = 0;
                        m_abort = 0;
                    end
                end else if (start_empty) begin
                    m_busy = 1;
                    m_addr = wa(cs, m_ip);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [15:0] c);
        reset        = 1'b1;
        load_new_ip  = 1'b0;
        new_ip       = 16'h0000;
        cs           = c;
        bus.mem_ack  = 1'b0;
        bus.mem_data = 16'h0000;
        bus.fifo_full = 1'b0;
        #1;
        check("rst_mem_access", 32'(bus.mem_access), 32'h0);
        check("rst_fifo_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        check("rst_fifo_reset", 32'(bus.fifo_reset), 32'h0);
        check("rst_mem_address", 32'(bus.mem_address), 32'h0);
        check("rst_fifo_wr_data", 32'(bus.fifo_wr_data), 32'h0);
        step();
        step();
        pushed.delete();
        addrs.delete();
    endtask

    task automatic wait_access(input string name);
        int n = 0;
        while (!bus.mem_access && n < 40) begin
            step();
            n++;
        end
        check(name, 32'(bus.mem_access), 32'h1);
    endtask

    task automatic serve(input string name, input logic [15:0] d);
        wait_access(name);
        bus.mem_ack  = 1'b1;
        bus.mem_data = d;
        step();
        bus.mem_ack  = 1'b0;
    endtask

    initial begin
        int cnt;
        // Reset vector fetch and byte order.
        do_reset(prefetch_unit_pkg::RESET_CS);
        reset = 1'b0;
        serve("t1_req0", 16'h3412);
        serve("t1_req1", 16'h7856);
        step(); step(); step();
        check("t1_addr0", 32'(addrs[0]), 32'h7fff8);
        check("t1_addr1", 32'(addrs[1]), 32'h7fff9);
        check("t1_byte0", 32'(pushed[0]), 32'h12);
        check("t1_byte1", 32'(pushed[1]), 32'h34);
        check("t1_byte2", 32'(pushed[2]), 32'h56);
        check("t1_byte3", 32'(pushed[3]), 32'h78);

        // Redirect to an odd IP from idle.
        do_reset(16'h0000);
        reset       = 1'b0;
        load_new_ip = 1'b1;
        new_ip      = 16'h0101;
        #1;
        check("t2_fifo_reset", 32'(bus.fifo_reset), 32'h1);
        check("t2_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        step();
        load_new_ip = 1'b0;
        check("t2_addr", 32'(bus.mem_address), 32'h00080);
        serve("t2_req", 16'hbbaa);
        step();
        wait_access("t2_next");
        check("t2_next_addr", 32'(bus.mem_address), 32'h00081);
        check("t2_count", 32'(pushed.size()), 32'h1);
        check("t2_byte", 32'(pushed[0]), 32'hbb);

        // Redirect during an outstanding bus cycle.
        do_reset(16'h0000);
        reset = 1'b0;
        wait_access("t3_req");
        step(); step();
        load_new_ip = 1'b1;
        new_ip      = 16'h2000;
        step();
        load_new_ip = 1'b0;
        step(); step();
        bus.mem_ack  = 1'b1;
        bus.mem_data = 16'hdead;
        step();
        bus.mem_ack  = 1'b0;
        check("t3_gap", 32'(bus.mem_access), 32'h0);
        step();
        check("t3_reissue", 32'(bus.mem_access), 32'h1);
        check("t3_addr", 32'(bus.mem_address), 32'h01000);
        check("t3_no_push", 32'(pushed.size()), 32'h0);

        // FIFO full holds the buffer and blocks new fetches.
        do_reset(16'h0000);
        reset = 1'b0;
        wait_access("t4_req");
        bus.mem_ack   = 1'b1;
        bus.mem_data  = 16'hc3a5;
        bus.fifo_full = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_wr", 32'(bus.fifo_wr_en), 32'h0);
            check("t4_hold_acc", 32'(bus.mem_access), 32'h0);
            step();
        end
        bus.fifo_full = 1'b0;
        step(); step(); step();
        check("t4_byte0", 32'(pushed[0]), 32'ha5);
        check("t4_byte1", 32'(pushed[1]), 32'hc3);
        check("t4_refetch", 32'(bus.mem_access), 32'h1);
        check("t4_addr", 32'(bus.mem_address), 32'h00001);

        // IP wrap and 20-bit physical address wrap.
        do_reset(16'h0000);
        reset       = 1'b0;
        load_new_ip = 1'b1;
        new_ip      = 16'hfffe;
        step();
        load_new_ip = 1'b0;
        check("t5_addr_fffe", 32'(bus.mem_address), 32'h07fff);
        serve("t5_req", 16'h1111);
        step();
        wait_access("t5_wrap");
        check("t5_addr_wrap", 32'(bus.mem_address), 32'h00000);
        do_reset(16'hf000);
        reset       = 1'b0;
        load_new_ip = 1'b1;
        new_ip      = 16'hffff;
        step();
        load_new_ip = 1'b0;
        check("t5_addr_top", 32'(bus.mem_address), 32'h7ffff);
        serve("t5_req2", 16'h1234);
        step();
        wait_access("t5_wrap2");
        check("t5_addr_seg", 32'(bus.mem_address), 32'h78000);
        check("t5_odd_count", 32'(pushed.size()), 32'h1);
        check("t5_odd_byte", 32'(pushed[0]), 32'h12);

        // Reset mid bus cycle, then a late ack.
        do_reset(16'h0000);
        reset = 1'b0;
        wait_access("t6_req");
        do_reset(16'h0000);
        reset        = 1'b0;
        bus.mem_ack  = 1'b1;
        bus.mem_data = 16'hffff;
        step();
        bus.mem_ack = 1'b0;
        check("t6_restart", 32'(bus.mem_access), 32'h1);
        check("t6_addr", 32'(bus.mem_address), 32'h00000);
        serve("t6_req2", 16'h5aa5);
        step(); step(); step();
        check("t6_count", 32'(pushed.size()), 32'h2);
        check("t6_byte0", 32'(pushed[0]), 32'ha5);
        check("t6_byte1", 32'(pushed[1]), 32'h5a);

        // Randomized traffic against the model.
        do_reset(16'h1234);
        reset = 1'b0;
        cnt   = 0;
        for (int i = 0; i < 5000; i++) begin
            bus.mem_ack = 1'b0;
            if (bus.mem_access) begin
                if (cnt == 0) begin
                    bus.mem_ack  = 1'b1;
                    bus.mem_data = 16'($urandom);
                    cnt          = $urandom_range(0, 3);
                end else begin
                    cnt--;
                end
            end
            bus.fifo_full = ($urandom_range(0, 3) == 0);
            load_new_ip   = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       new_ip = 16'hffff;
                1:       new_ip = 16'hfffe;
                default: new_ip = 16'($urandom);
            endcase
            if ($urandom_range(0, 39) == 0) cs = 16'($urandom);
            reset = ($urandom_range(0, 699) == 0);
            if (reset) begin
                load_new_ip = 1'b0;
                cnt         = 0;
            end
            step();
        end
        reset       = 1'b0;
        load_new_ip = 1'b0;
        bus.mem_ack = 1'b0;
        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
